// File: rtl/instr_fetch_queue_pkg.sv
// Shared processor definitions: instruction word layout, key opcodes, issue-FSM states.
// No logic, no latency.
// Not applicable (types and constants only).
package proc_pkg;

  localparam int INST_W = 16;

  localparam logic [2:0] OPC_HALT = 3'b111;
  localparam logic [2:0] OPC_ALU  = 3'b011;

  // Field positions shared with the execute stage
  localparam int OPC_LSB  = 0;
  localparam int OPC_MSB  = 2;
  localparam int FUNC_LSB = 3;
  localparam int FUNC_MSB = 6;
  localparam int REG2_LSB = 7;
  localparam int REG2_MSB = 9;
  localparam int REG1_LSB = 10;
  localparam int REG1_MSB = 12;
  localparam int REGW_LSB = 13;
  localparam int REGW_MSB = 15;

  // Packed view of one instruction word, MSB field first
  typedef struct packed {
    logic [REGW_MSB-REGW_LSB:0] regw;
    logic [REG1_MSB-REG1_LSB:0] reg1;
    logic [REG2_MSB-REG2_LSB:0] reg2;
    logic [FUNC_MSB-FUNC_LSB:0] func;
    logic [OPC_MSB-OPC_LSB:0]   opcode;
  } inst_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } issue_state_e;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Byte-in / instruction-out bundle between the byte source, the fetch queue and execute.
// No logic, no latency.
// byte_valid/byte_ready on input; inst_valid/inst_ready on output.
interface instr_fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
);
  import proc_pkg::*;

  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              sync_clr;
  logic              resume;
  logic [INST_W-1:0] inst_out;
  logic              inst_valid;
  logic              inst_ready;
  logic              halted;
  logic [CW-1:0]     fifo_count;
  logic [7:0]        issue_count;

  // Byte source / execute side
  modport master (
    output byte_in, byte_valid, sync_clr, resume, inst_ready,
    input  byte_ready, inst_out, inst_valid, halted, fifo_count, issue_count
  );

  // Fetch queue side
  modport slave (
    input  byte_in, byte_valid, sync_clr, resume, inst_ready,
    output byte_ready, inst_out, inst_valid, halted, fifo_count, issue_count
  );

endinterface

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with count and synchronous clear; head is read combinationally.
// Write visible at the head the cycle after push.
// Push ignored when full, pop ignored when empty; clear overrides both.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign do_push  = push_i & ~full_o & ~clr_i;
  assign do_pop   = pop_i & ~empty_o & ~clr_i;

  // Storage array; data needs no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  // Pointer and occupancy next-state; pointers wrap naturally at power-of-two depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Assembles low-first byte pairs into instruction words, queues them, issues to execute; HALT pauses issue.
// High byte accepted in cycle N gives inst_valid in cycle N+1.
// byte_ready drops only when a high byte is pending and the FIFO is full; issue waits on inst_ready.
module instr_fetch_queue
  import proc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_queue_if.slave bus
);

  logic         phase_q, phase_d;     // 0: expecting low byte, 1: expecting high byte
  logic [7:0]   low_q, low_d;
  issue_state_e state_q, state_d;
  logic [7:0]   issue_cnt_q, issue_cnt_d;

  inst_t        head;
  logic         fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic         byte_acc, push, pop, hs, halt_pop, inst_vld;

  // A low byte can always be latched; a high byte needs room for the completed word
  assign bus.byte_ready = ~phase_q | ~fifo_full;
  assign byte_acc       = bus.byte_valid & bus.byte_ready & ~bus.sync_clr;
  assign push           = byte_acc & phase_q;
  assign hs             = inst_vld & bus.inst_ready & ~bus.sync_clr;
  assign pop            = hs | (halt_pop & ~bus.sync_clr);

  assign bus.inst_valid  = inst_vld;
  assign bus.inst_out    = fifo_empty ? '0 : head;
  assign bus.halted      = (state_q == HALTED);
  assign bus.fifo_count  = fifo_cnt;
  assign bus.issue_count = issue_cnt_q;

  sync_fifo #(
    .WIDTH (INST_W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (bus.sync_clr),
    .push_i   (push),
    .wr_dat_i ({bus.byte_in, low_q}),
    .pop_i    (pop),
    .rd_dat_o (head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_cnt)
  );

  // Byte assembler: flush drops any half-built word
  always_comb begin
    phase_d = phase_q;
    low_d   = low_q;
    if (bus.sync_clr) begin
      phase_d = 1'b0;
      low_d   = '0;
    end else if (byte_acc) begin
      if (!phase_q) begin
        low_d   = bus.byte_in;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
      end
    end
  end

  // Issue FSM: a HALT at the head is swallowed without a handshake and parks the FSM
  always_comb begin
    state_d  = state_q;
    inst_vld = 1'b0;
    halt_pop = 1'b0;
    case (state_q)
      RUN: begin
        if (!fifo_empty) begin
          if (head.opcode == OPC_HALT) begin
            halt_pop = 1'b1;
            state_d  = HALTED;
          end else begin
            inst_vld = 1'b1;
          end
        end
      end
      HALTED: begin
        if (bus.resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (bus.sync_clr) state_d = RUN;
  end

  // Issued-instruction counter survives a flush and wraps at 8 bits
  always_comb begin
    issue_cnt_d = issue_cnt_q + (hs ? 8'd1 : 8'd0);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= 1'b0;
      low_q       <= '0;
      state_q     <= RUN;
      issue_cnt_q <= '0;
    end else begin
      phase_q     <= phase_d;
      low_q       <= low_d;
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

endmodule
